hilo_muldiv_ctrl: RTL and testbench

//  Owns the 64-bit HiLo register and sequences every EX-stage op that touches it.
//  Ops covered: multiply, multiply-accumulate/subtract, divide, move-to and move-from.

---
 rtl/hilo_pkg.sv | 56 +++++
 rtl/hilo_div_step.sv | 24 ++
 rtl/hilo_muldiv_ctrl.sv | 149 ++++++++++++++
 tb/tb_hilo_muldiv_ctrl.sv | 220 ++++++++++++++++++++++
 4 files changed

// File: rtl/hilo_pkg.sv
// HiLo mul/div controller shared definitions: op codes, FSM encoding, op-class helpers.
// Latency: none (constants and pure functions only).
// Backpressure: n/a.
package hilo_pkg;

  localparam logic [3:0] OP_NOP   = 4'd0;
  localparam logic [3:0] OP_MULT  = 4'd1;
  localparam logic [3:0] OP_MULTU = 4'd2;
  localparam logic [3:0] OP_MADD  = 4'd3;
  localparam logic [3:0] OP_MADDU = 4'd4;
  localparam logic [3:0] OP_MSUB  = 4'd5;
  localparam logic [3:0] OP_MSUBU = 4'd6;
  localparam logic [3:0] OP_DIV   = 4'd7;
  localparam logic [3:0] OP_DIVU  = 4'd8;
  localparam logic [3:0] OP_MTHI  = 4'd9;
  localparam logic [3:0] OP_MTLO  = 4'd10;
  localparam logic [3:0] OP_MFHI  = 4'd11;
  localparam logic [3:0] OP_MFLO  = 4'd12;

  // Restoring divide needs one iteration per operand bit.
  localparam int DIV_ITERS = 32;

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_MUL    = 2'd1;
  localparam logic [1:0] ST_DIV    = 2'd2;
  localparam logic [1:0] ST_DIVFIX = 2'd3;

  // How the finished product is folded into HiLo.
  localparam logic [1:0] ACC_SET = 2'd0;
  localparam logic [1:0] ACC_ADD = 2'd1;
  localparam logic [1:0] ACC_SUB = 2'd2;

  function automatic logic is_mul(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_MSUBU);
  endfunction

  function automatic logic is_muldiv(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_DIVU);
  endfunction

  // Any op that reads or writes HiLo; these must wait out an in-flight sequence.
  function automatic logic is_hilo_op(input logic [3:0] op);
    return (op >= OP_MULT) && (op <= OP_MFLO);
  endfunction

  function automatic logic is_signed(input logic [3:0] op);
    return (op == OP_MULT) || (op == OP_MADD) || (op == OP_MSUB) || (op == OP_DIV);
  endfunction

  function automatic logic [1:0] acc_of(input logic [3:0] op);
    if ((op == OP_MADD) || (op == OP_MADDU)) return ACC_ADD;
    if ((op == OP_MSUB) || (op == OP_MSUBU)) return ACC_SUB;
    return ACC_SET;
  endfunction

endpackage

// File: rtl/hilo_div_step.sv
// One restoring-division iteration on unsigned 32-bit magnitudes.
// Latency: purely combinational.
// Backpressure: none; the caller decides when to register the result.
module hilo_div_step (
  input  logic [31:0] rem,
  input  logic [31:0] quo,
  input  logic [31:0] dvsr,
  output logic [31:0] rem_nxt,
  output logic [31:0] quo_nxt
);

  logic [32:0] shifted;
  logic        fits;

  // Shift the next dividend bit into the partial remainder and try to subtract.
  // The difference is taken in 32 bits: whenever it is kept it is below dvsr.
  always_comb begin
    shifted = {rem, quo[31]};
    fits    = (shifted >= {1'b0, dvsr});
    rem_nxt = fits ? (shifted[31:0] - dvsr) : shifted[31:0];
    quo_nxt = {quo[30:0], fits};
  end

endmodule

// File: rtl/hilo_muldiv_ctrl.sv
// HiLo register owner: sequences mul/madd/msub/div/mthi/mtlo/mfhi/mflo from EX.
// Latency: mul-class MUL_CYCLES edges, divide DIV_ITERS+1 edges, MT*/MF* single cycle.
// Backpressure: Stall holds EX while a sequence is in flight and a HiLo op is presented.
module hilo_muldiv_ctrl
  import hilo_pkg::*;
#(
  parameter int MUL_CYCLES = 4
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic        OpValid,
  input  logic [3:0]  Op,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        Flush,
  output logic        Stall,
  output logic        Busy,
  output logic        Done,
  output logic [31:0] ReadData,
  output logic [31:0] Hi,
  output logic [31:0] Lo
);

  localparam int CNT_W = 6;

  logic [1:0]       state;
  logic [CNT_W-1:0] cnt;
  logic [63:0]      prod;
  logic [1:0]       acc_mode;
  logic [31:0]      rem, quo, dvsr;
  logic             q_neg, r_neg, dvz;

  logic             accept, sgn;
  logic [63:0]      ext_a, ext_b, hilo_new;
  logic [31:0]      a_abs, b_abs, rem_nxt, quo_nxt, quo_fix, rem_fix;

  // Busy is a pure decode of the state flops, so it carries no combinational input path.
  assign Busy   = (state != ST_IDLE);
  assign Stall  = OpValid & Busy & is_hilo_op(Op);
  assign accept = OpValid & ~Stall & ~Flush;
  assign sgn    = is_signed(Op);

  // Operand conditioning, product folding, divide sign fix-up and the MF* read port.
  always_comb begin
    // Sign- or zero-extend to 64 bits so a single multiply serves both flavours mod 2^64.
    ext_a   = sgn ? {{32{A[31]}}, A} : {32'b0, A};
    ext_b   = sgn ? {{32{B[31]}}, B} : {32'b0, B};
    a_abs   = (sgn & A[31]) ? (~A + 32'd1) : A;
    b_abs   = (sgn & B[31]) ? (~B + 32'd1) : B;
    case (acc_mode)
      ACC_ADD: hilo_new = {Hi, Lo} + prod;
      ACC_SUB: hilo_new = {Hi, Lo} - prod;
      default: hilo_new = prod;
    endcase
    // Divide by zero returns all-ones quotient; the remainder already equals A.
    quo_fix  = dvz ? 32'hFFFF_FFFF : (q_neg ? (~quo + 32'd1) : quo);
    rem_fix  = r_neg ? (~rem + 32'd1) : rem;
    ReadData = 32'd0;
    if (Op == OP_MFHI) ReadData = Hi;
    else if (Op == OP_MFLO) ReadData = Lo;
  end

  hilo_div_step u_div_step (
    .rem     (rem),
    .quo     (quo),
    .dvsr    (dvsr),
    .rem_nxt (rem_nxt),
    .quo_nxt (quo_nxt)
  );

  // Sequencer plus HiLo register; Flush in any busy state abandons the op without writing.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state    <= ST_IDLE;
      cnt      <= '0;
      prod     <= '0;
      acc_mode <= ACC_SET;
      rem      <= '0;
      quo      <= '0;
      dvsr     <= '0;
      q_neg    <= 1'b0;
      r_neg    <= 1'b0;
      dvz      <= 1'b0;
      Done     <= 1'b0;
      Hi       <= '0;
      Lo       <= '0;
    end else begin
      Done <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (is_muldiv(Op)) begin
              if (is_mul(Op)) begin
                state    <= ST_MUL;
                prod     <= ext_a * ext_b;
                acc_mode <= acc_of(Op);
                cnt      <= CNT_W'(MUL_CYCLES - 1);
              end else begin
                state <= ST_DIV;
                rem   <= '0;
                quo   <= a_abs;
                dvsr  <= b_abs;
                q_neg <= sgn & (A[31] ^ B[31]);
                r_neg <= sgn & A[31];
                dvz   <= (B == 32'd0);
                cnt   <= CNT_W'(DIV_ITERS - 1);
              end
            end else if (Op == OP_MTHI) begin
              Hi <= A;
            end else if (Op == OP_MTLO) begin
              Lo <= A;
            end
          end
        end
        ST_MUL: begin
          if (Flush) begin
            state <= ST_IDLE;
          end else if (cnt == '0) begin
            {Hi, Lo} <= hilo_new;
            Done     <= 1'b1;
            state    <= ST_IDLE;
          end else begin
            cnt <= cnt - 1'b1;
          end
        end
        ST_DIV: begin
          if (Flush) begin
            state <= ST_IDLE;
          end else begin
            rem <= rem_nxt;
            quo <= quo_nxt;
            if (cnt == '0) state <= ST_DIVFIX;
            else           cnt   <= cnt - 1'b1;
          end
        end
        ST_DIVFIX: begin
          if (!Flush) begin
            Lo   <= quo_fix;
            Hi   <= rem_fix;
            Done <= 1'b1;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_hilo_muldiv_ctrl.sv
// Self-checking bench for hilo_muldiv_ctrl with a scoreboard of expected Hi:Lo results.
// Latency: checks mul at 4 edges and divide at 33 edges after accept.
// Backpressure: exercises Stall on a held MFLO behind a divide.
module tb_hilo_muldiv_ctrl;
  import hilo_pkg::*;

  logic        Clk, Reset, OpValid, Flush;
  logic [3:0]  Op;
  logic [31:0] A, B;
  logic        Stall, Busy, Done;
  logic [31:0] ReadData, Hi, Lo;

  int passed = 0;
  int total  = 0;
  logic [63:0] exp_q[$];

  hilo_muldiv_ctrl #(.MUL_CYCLES(4)) dut (
    .Clk(Clk), .Reset(Reset), .OpValid(OpValid), .Op(Op), .A(A), .B(B), .Flush(Flush),
    .Stall(Stall), .Busy(Busy), .Done(Done), .ReadData(ReadData), .Hi(Hi), .Lo(Lo)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  // Present an op for one edge; returns at accept edge + 1.
  task automatic issue(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    Op = op; A = a; B = b; OpValid = 1'b1;
    @(posedge Clk); #1;
    OpValid = 1'b0; Op = OP_NOP;
  endtask

  task automatic wait_done(input int limit, output int lat, output int busy_cnt);
    logic [63:0] exp;
    lat = 0; busy_cnt = 0;
    while (Done !== 1'b1 && lat < limit) begin
      busy_cnt += int'(Busy);
      @(posedge Clk); #1;
      lat++;
    end
    total++;
    if (Done !== 1'b1) $display("FAIL done_timeout: no Done within %0d cycles", limit);
    else passed++;
    if (exp_q.size() > 0) begin
      exp = exp_q.pop_front();
      total++;
      if ({Hi, Lo} !== exp) $display("FAIL hilo_result: got %h:%h want %h:%h", Hi, Lo, exp[63:32], exp[31:0]);
      else passed++;
    end
  endtask

  task automatic test_reset;
    Reset = 1'b0; OpValid = 1'b0; Op = OP_NOP; A = '0; B = '0; Flush = 1'b0;
    #3 Reset = 1'b1;
    @(posedge Clk); #1;
    total++;
    if ({Hi, Lo, Busy, Done, Stall} !== 67'd0)
      $display("FAIL reset_state: Hi=%h Lo=%h Busy=%b Done=%b Stall=%b want all 0", Hi, Lo, Busy, Done, Stall);
    else passed++;
    Reset = 1'b0;
    @(posedge Clk); #1;
  endtask

  task automatic test_mult;
    int lat, bc;
    issue(OP_MULT, 32'hFFFF_FFFD, 32'd7);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFEB);
    wait_done(20, lat, bc);
    total++;
    if (lat !== 4) $display("FAIL mult_latency: got %0d want 4", lat); else passed++;
    total++;
    if (bc !== 4) $display("FAIL mult_busy_cycles: got %0d want 4", bc); else passed++;
    total++;
    if (Busy !== 1'b0) $display("FAIL mult_busy_after_done: got %b want 0", Busy); else passed++;
    @(posedge Clk); #1;
    total++;
    if (Done !== 1'b0) $display("FAIL mult_done_pulse: got %b want 0", Done); else passed++;
  endtask

  task automatic test_madd;
    int lat, bc;
    issue(OP_MTHI, 32'd1, 32'd0);
    total++;
    if (Hi !== 32'd1 || Busy !== 1'b0) $display("FAIL mthi: Hi=%h Busy=%b want 1 0", Hi, Busy); else passed++;
    issue(OP_MTLO, 32'd2, 32'd0);
    Op = OP_MFHI; #1;
    total++;
    if (ReadData !== 32'd1) $display("FAIL mfhi_read: got %h want 1", ReadData); else passed++;
    Op = OP_MFLO; #1;
    total++;
    if (ReadData !== 32'd2) $display("FAIL mflo_read: got %h want 2", ReadData); else passed++;
    Op = 4'd14; #1;
    total++;
    if (ReadData !== 32'd0) $display("FAIL read_other: got %h want 0", ReadData); else passed++;
    Op = OP_NOP;
    @(posedge Clk); #1;
    issue(OP_MADDU, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    exp_q.push_back(64'hFFFF_FFFF_0000_0003);
    wait_done(20, lat, bc);
    issue(OP_MSUB, 32'hFFFF_FFFF, 32'd1);
    exp_q.push_back(64'hFFFF_FFFF_0000_0004);
    wait_done(20, lat, bc);
  endtask

  task automatic test_div;
    int lat, bc;
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd2);
    exp_q.push_back(64'hFFFF_FFFF_FFFF_FFFD);
    wait_done(60, lat, bc);
    total++;
    if (lat !== 33) $display("FAIL div_latency: got %0d want 33", lat); else passed++;
    issue(OP_DIVU, 32'd7, 32'd0);
    exp_q.push_back(64'h0000_0007_FFFF_FFFF);
    wait_done(60, lat, bc);
    issue(OP_DIV, 32'hFFFF_FFF9, 32'd0);
    exp_q.push_back(64'hFFFF_FFF9_FFFF_FFFF);
    wait_done(60, lat, bc);
    issue(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    exp_q.push_back(64'h0000_0000_8000_0000);
    wait_done(60, lat, bc);
    issue(OP_DIVU, 32'hFFFF_FFFF, 32'd16);
    exp_q.push_back(64'h0000_000F_0FFF_FFFF);
    wait_done(60, lat, bc);
  endtask

  task automatic test_back_to_back;
    int cyc, stall_bad;
    logic [63:0] exp;
    issue(OP_DIV, 32'd100, 32'd7);
    exp_q.push_back(64'h0000_0002_0000_000E);
    Op = 4'd13; OpValid = 1'b1; #1;
    total++;
    if (Stall !== 1'b0) $display("FAIL stall_reserved_op: got %b want 0", Stall); else passed++;
    Op = OP_MFLO; #1;
    cyc = 0; stall_bad = 0;
    while (Done !== 1'b1 && cyc < 60) begin
      if (Stall !== 1'b1) stall_bad++;
      @(posedge Clk); #1;
      cyc++;
    end
    total++;
    if (stall_bad !== 0 || Done !== 1'b1)
      $display("FAIL mflo_stall: cycles without stall %0d, Done=%b want 0 and 1", stall_bad, Done);
    else passed++;
    total++;
    if (Stall !== 1'b0 || ReadData !== 32'd14)
      $display("FAIL mflo_after_done: Stall=%b ReadData=%h want 0 0000000e", Stall, ReadData);
    else passed++;
    exp = exp_q.pop_front();
    total++;
    if ({Hi, Lo} !== exp) $display("FAIL b2b_hilo: got %h:%h want %h", Hi, Lo, exp); else passed++;
    @(posedge Clk); #1;
    OpValid = 1'b0; Op = OP_NOP;
  endtask

  task automatic test_flush;
    int seen;
    issue(OP_MTHI, 32'd5, 32'd0);
    issue(OP_MTLO, 32'd6, 32'd0);
    issue(OP_DIV, 32'd100, 32'd3);
    repeat (10) begin @(posedge Clk); #1; end
    Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    total++;
    if (Busy !== 1'b0 || Done !== 1'b0) $display("FAIL flush_div: Busy=%b Done=%b want 0 0", Busy, Done); else passed++;
    seen = 0;
    repeat (40) begin @(posedge Clk); #1; seen += int'(Done); end
    total++;
    if (seen !== 0 || Hi !== 32'd5 || Lo !== 32'd6)
      $display("FAIL flush_div_hilo: Done pulses %0d Hi:Lo %h:%h want 0 5:6", seen, Hi, Lo);
    else passed++;
    // Flush in the mul writeback cycle.
    issue(OP_MULT, 32'd2, 32'd2);
    repeat (3) begin @(posedge Clk); #1; end
    Flush = 1'b1;
    @(posedge Clk); #1;
    Flush = 1'b0;
    total++;
    if (Done !== 1'b0 || Busy !== 1'b0 || Hi !== 32'd5 || Lo !== 32'd6)
      $display("FAIL flush_mul_wb: Done=%b Busy=%b Hi:Lo %h:%h want 0 0 5:6", Done, Busy, Hi, Lo);
    else passed++;
    // Flush beats a simultaneous accept while idle.
    Flush = 1'b1;
    issue(OP_MTLO, 32'd99, 32'd0);
    Flush = 1'b0;
    total++;
    if (Lo !== 32'd6) $display("FAIL flush_drops_op: Lo=%h want 6", Lo); else passed++;
  endtask

  task automatic test_reset_mid;
    int lat, bc;
    issue(OP_MULT, 32'd5, 32'd5);
    @(posedge Clk); #1;
    #2 Reset = 1'b1;
    #1;
    total++;
    if ({Hi, Lo, Busy, Done} !== 66'd0)
      $display("FAIL async_reset: Hi=%h Lo=%h Busy=%b Done=%b want all 0", Hi, Lo, Busy, Done);
    else passed++;
    @(posedge Clk); #1;
    Reset = 1'b0;
    @(posedge Clk); #1;
    issue(OP_MULT, 32'd2, 32'd3);
    exp_q.push_back(64'd6);
    wait_done(20, lat, bc);
  endtask

  initial begin
    test_reset();
    test_mult();
    test_madd();
    test_div();
    test_back_to_back();
    test_flush();
    test_reset_mid();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
